fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end of the 5-stage pipeline: owns the PC register, the instruction-memory request port and the IF/ID pipeline register. It consumes the stall/flush/redirect controls produced by the hazard unit: it holds on stalls, squashes on flushes, and redirects to the EX-stage branch/jump target. A one-entry hold buffer absorbs an instruction returning from the 1-cycle-latency synchronous instruction memory while decode is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP_INSTR, 32'h0000_0013, instruction word loaded into IF/ID for bubbles (addi x0,x0,0)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall_f  in  1  hold PC, issue no new fetch
- stall_d  in  1  hold IF/ID register contents
- flush_d  in  1  squash IF/ID and any in-flight/held instruction
- pc_src_e  in  1  redirect fetch to pc_target_e this cycle
- pc_target_e  in  32  branch/jump target from EX
- imem_req  out  1  fetch request this cycle
- imem_addr  out  32  fetch address (word aligned)
- imem_rdata  in  32  instruction for the address requested in the previous cycle
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc_plus4_d  out  32  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- State: pc_f (32), req_valid_q + req_pc_q (response due this cycle), hold_valid + hold_instr + hold_pc, IF/ID register (instr_d, pc_d, pc_plus4_d, valid_d).
- imem_addr = pc_src_e ? pc_target_e : pc_f (combinational).
- imem_req = !rst && (pc_src_e || !(stall_f || stall_d)). Redirect overrides stall.
- PC update: rst -> RESET_PC; else pc_src_e -> pc_target_e+4; else imem_req -> pc_f+4; else hold. All PC arithmetic mod 2^32 (0xFFFF_FFFC+4 wraps to 0).
- Request tracking: req_valid_q <= imem_req, req_pc_q <= imem_addr, every cycle (0 on rst).
- IF/ID source priority: hold buffer (if hold_valid) else live response (if req_valid_q) else bubble.
- IF/ID update priority: rst > flush_d > stall_d > load.
  - rst / flush_d: instr_d=NOP_INSTR, valid_d=0, pc_d=0, pc_plus4_d=0; hold_valid<=0; live response discarded.
  - stall_d: IF/ID holds; if req_valid_q && !hold_valid, capture imem_rdata/req_pc_q into hold buffer.
  - load: IF/ID <= selected source (pc_plus4_d = pc_d+4, valid_d=1) or bubble; hold_valid<=0 if hold used.
- Hold buffer never overflows: a request is only issued while stall_d=0 or on redirect (which flushes the hold); a capture with hold_valid=1 cannot occur and is a verification assertion.
- flush_d without pc_src_e: squashes IF/ID, hold and live response; fetch continues sequentially from pc_f.

## Timing
- Reset values: pc_f=RESET_PC, req_valid_q=0, hold_valid=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0; imem_req=0 while rst=1.
- Fetch latency: address issued cycle N, imem_rdata valid cycle N+1, instr_d/valid_d visible cycle N+2.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC; instr_d valid two cycles later.
- Steady state: one instruction per cycle, pc_d increments by 4 each cycle.
- Redirect in cycle N (pc_src_e=flush_d=1): target requested in cycle N; wrong-path response in cycle N discarded; IF/ID bubble in N+1; target instruction in IF/ID at N+2; penalty 2 bubbles in decode.
- Stall of K cycles: IF/ID unchanged for K cycles, no imem_req; instruction in flight at stall start is held; on release it loads from hold in the first cycle and fetch resumes in the same cycle, giving no lost or duplicated instruction.
- Reset mid-stall or mid-redirect: all state returns to reset values next edge; hold contents lost.

## Test plan
- Reset release, memory returns addr>>2: cycles 2,3,4 show pc_d=0x0,0x4,0x8, valid_d=1, imem_addr=0x0,0x4,0x8,... from cycle 0.
- stall_f=stall_d=1 for 3 cycles while pc_d=0x8: IF/ID holds 0x8, imem_req=0, hold captures 0xC; after release pc_d sequence 0xC,0x10,0x14 with no gap or repeat.
- pc_src_e=flush_d=1, pc_target_e=0x100 while fetching 0x20: imem_addr=0x100 that cycle, next cycle valid_d=0/instr_d=0x13, then pc_d=0x100,0x104.
- Redirect to 0x200 during an active stall with hold full: hold dropped, pc_d=0x200 appears two cycles later, hold instruction never reaches decode.
- RESET_PC=0xFFFF_FFF8: pc_d sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 (wrap), pc_plus4_d of 0xFFFF_FFFC = 0x0.
- rst asserted while stalled with hold_valid=1: next cycle valid_d=0, instr_d=0x13, hold_valid=0, imem_req=0; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch front end: PC, imem request port, hold buffer
//            and IF/ID pipeline register.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);
    localparam logic [31:0] c_pc_step = 32'd4;

    logic [31:0] r_pc_f;
    logic        r_req_valid;
    logic [31:0] r_req_pc;
    logic        r_hold_valid;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;

    logic        w_fetch;
    logic [31:0] w_fetch_addr;
    logic        w_src_valid;
    logic [31:0] w_src_instr;
    logic [31:0] w_src_pc;

    // A redirect always wins over a stall so the target is requested at once.
    assign w_fetch      = !rst && (pc_src_e || !(stall_f || stall_d));
    assign w_fetch_addr = pc_src_e ? pc_target_e : r_pc_f;

    assign imem_req   = w_fetch;
    assign imem_addr  = w_fetch_addr;
    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;
    assign valid_d    = r_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f <= RESET_PC;
        end else if (w_fetch) begin
            r_pc_f <= w_fetch_addr + c_pc_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid <= 1'b0;
            r_req_pc    <= '0;
        end else begin
            r_req_valid <= w_fetch;
            r_req_pc    <= w_fetch_addr;
        end
    end

    // The held instruction is older than any live response, so it goes first.
    always_comb begin
        w_src_valid = 1'b0;
        w_src_instr = NOP_INSTR;
        w_src_pc    = '0;
        if (r_hold_valid) begin
            w_src_valid = 1'b1;
            w_src_instr = r_hold_instr;
            w_src_pc    = r_hold_pc;
        end else if (r_req_valid) begin
            w_src_valid = 1'b1;
            w_src_instr = imem_rdata;
            w_src_pc    = r_req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
            r_hold_valid <= 1'b0;
        end else if (stall_d) begin
            if (r_req_valid && !r_hold_valid) begin
                r_hold_valid <= 1'b1;
                r_hold_instr <= imem_rdata;
                r_hold_pc    <= r_req_pc;
            end
        end else begin
            r_instr_d    <= w_src_instr;
            r_pc_d       <= w_src_pc;
            r_pc_plus4_d <= w_src_valid ? (w_src_pc + c_pc_step) : '0;
            r_valid_d    <= w_src_valid;
            r_hold_valid <= 1'b0;
        end
    end

    // Requests only issue while decode is free or on a flushing redirect,
    // so a second capture into an occupied hold buffer is impossible.
    always_ff @(posedge clk) begin
        if (!rst && !flush_d && stall_d && r_req_valid) begin
            assert (!r_hold_valid);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Scoreboard bench for fetch_stage against a queue-based fetch model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;
    localparam logic [31:0] c_nop   = 32'h0000_0013;
    localparam logic [31:0] c_reset = 32'h0000_0000;
    localparam logic [31:0] c_wrap  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e, imem_rdata, imem_addr;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        imem_req, valid_d;

    logic        wr_rst;
    logic        wr_zero = 1'b0;
    logic [31:0] wr_tgt = 32'h0;
    logic [31:0] wr_rdata, wr_addr, wr_instr, wr_pc, wr_pc4;
    logic        wr_req, wr_valid;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(c_reset), .NOP_INSTR(c_nop)) dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
    );

    fetch_stage #(.RESET_PC(c_wrap), .NOP_INSTR(c_nop)) dut_wrap (
        .clk(clk), .rst(wr_rst), .stall_f(wr_zero), .stall_d(wr_zero),
        .flush_d(wr_zero), .pc_src_e(wr_zero), .pc_target_e(wr_tgt),
        .imem_req(wr_req), .imem_addr(wr_addr), .imem_rdata(wr_rdata),
        .instr_d(wr_instr), .pc_d(wr_pc), .pc_plus4_d(wr_pc4), .valid_d(wr_valid)
    );

    // Instruction memory contents: each word holds its own word index.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a >> 2;
    endfunction

    always @(posedge clk) begin
        imem_rdata <= mem_f(imem_addr);
        wr_rdata   <= mem_f(wr_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the architectural fetch stream as a FIFO of fetched PCs
    // that have not yet entered decode, plus the expected IF/ID contents.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_t;

    ifid_t       sb_q[$];
    logic [31:0] m_pend[$];
    logic [31:0] m_pc;
    ifid_t       m_ifid;

    function automatic ifid_t bubble();
        return '{1'b0, c_nop, 32'h0, 32'h0};
    endfunction

    always @(posedge clk) begin : model
        logic        m_req;
        logic [31:0] m_addr;
        logic [31:0] p;
        if (rst) begin
            m_pc = c_reset;
            m_pend.delete();
            m_ifid = bubble();
        end else begin
            m_req  = pc_src_e || !(stall_f || stall_d);
            m_addr = pc_src_e ? pc_target_e : m_pc;
            if (flush_d) begin
                m_pend.delete();
                m_ifid = bubble();
            end else if (!stall_d) begin
                if (m_pend.size() > 0) begin
                    p = m_pend.pop_front();
                    m_ifid = '{1'b1, mem_f(p), p, p + 32'd4};
                end else begin
                    m_ifid = bubble();
                end
            end
            if (m_req) begin
                m_pend.push_back(m_addr);
                m_pc = m_addr + 32'd4;
            end
        end
        sb_q.push_back(m_ifid);
    end

    always @(negedge clk) begin : monitor
        ifid_t e;
        logic  ereq;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("valid_d", {31'd0, valid_d}, {31'd0, e.valid});
            chk("instr_d", instr_d, e.instr);
            chk("pc_d", pc_d, e.pc);
            chk("pc_plus4_d", pc_plus4_d, e.pc4);
        end
        ereq = !rst && (pc_src_e || !(stall_f || stall_d));
        chk("imem_req", {31'd0, imem_req}, {31'd0, ereq});
        if (ereq) chk("imem_addr", imem_addr, pc_src_e ? pc_target_e : m_pc);
    end

    task automatic cyc(input logic r, input logic sf, input logic sd,
                       input logic fl, input logic ps, input logic [31:0] t);
        rst = r; stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = ps; pc_target_e = t;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic stall();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src_e = 1'b0; pc_target_e = 32'h0; wr_rst = 1'b1;

        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("reset_valid", {31'd0, valid_d}, 32'd0);
        chk("reset_instr", instr_d, c_nop);
        chk("reset_pc", pc_d, 32'h0);
        chk("reset_req", {31'd0, imem_req}, 32'd0);

        // Reset release: first instruction two cycles later, then one per cycle.
        repeat (2) idle();
        chk("first_pc", pc_d, 32'h0);
        chk("first_valid", {31'd0, valid_d}, 32'd1);
        repeat (2) idle();
        chk("seq_pc", pc_d, 32'h8);
        chk("seq_instr", instr_d, 32'h2);

        // Three-cycle stall: in-flight 0xC is held and delivered on release.
        repeat (3) stall();
        chk("stall_hold_pc", pc_d, 32'h8);
        chk("stall_no_req", {31'd0, imem_req}, 32'd0);
        idle();
        chk("release_pc", pc_d, 32'hC);
        idle();
        chk("release_next_pc", pc_d, 32'h10);

        // Redirect to 0x100.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        chk("redir_bubble_valid", {31'd0, valid_d}, 32'd0);
        chk("redir_bubble_instr", instr_d, c_nop);
        idle();
        chk("redir_target_pc", pc_d, 32'h100);
        idle();
        chk("redir_next_pc", pc_d, 32'h104);

        // Redirect during a stall with the hold buffer full.
        repeat (2) stall();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        chk("stall_redir_bubble", {31'd0, valid_d}, 32'd0);
        idle();
        chk("stall_redir_pc", pc_d, 32'h200);
        chk("stall_redir_instr", instr_d, 32'h80);

        // Reset while stalled with a held instruction.
        repeat (2) stall();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_stall_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_stall_instr", instr_d, c_nop);
        chk("rst_stall_req", {31'd0, imem_req}, 32'd0);
        repeat (2) idle();
        chk("rst_restart_pc", pc_d, c_reset);
        chk("rst_restart_valid", {31'd0, valid_d}, 32'd1);

        // PC wrap-around on the second instance.
        wr_rst = 1'b0;
        repeat (2) idle();
        chk("wrap_pc0", wr_pc, 32'hFFFF_FFF8);
        chk("wrap_valid", {31'd0, wr_valid}, 32'd1);
        idle();
        chk("wrap_pc1", wr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", wr_pc4, 32'h0);
        idle();
        chk("wrap_pc2", wr_pc, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic        r, sf, sd, fl, ps;
            logic [31:0] t;
            r  = ($urandom_range(0, 299) == 0);
            sd = ($urandom_range(0, 3) == 0);
            sf = sd | ($urandom_range(0, 7) == 0);
            ps = ($urandom_range(0, 9) == 0);
            fl = ps | ($urandom_range(0, 19) == 0);
            t  = $urandom;
            t[1:0] = 2'b00;
            cyc(r, sf, sd, fl, ps, t);
        end
        repeat (3) idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
